// File: rtl/conv_pkg.sv
// Shared types and arithmetic helpers for the 1-D streaming convolution engine.
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Accumulator width: full-width products plus growth for summing kern_len of them.
    function automatic int unsigned acc_width(input int unsigned data_w, input int unsigned kern_len);
        return 2 * data_w + $clog2(kern_len);
    endfunction

    // Clamp a sign-extended accumulator value into the signed out_w range.
    function automatic logic signed [63:0] sat_to(input logic signed [63:0] v, input int unsigned out_w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi) begin
            return hi;
        end
        if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/conv_window_mac.sv
// Two-stage window multiply-accumulate: registered products, then saturated sum.
module conv_window_mac
    import conv_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned KERN_LEN = 3,
    parameter int unsigned OUT_W    = 18
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         in_valid,
    input  logic                         in_last,
    input  logic [KERN_LEN*DATA_W-1:0]   win,
    input  logic [KERN_LEN*DATA_W-1:0]   kern,
    output logic                         out_valid,
    output logic                         out_last,
    output logic [OUT_W-1:0]             out_data
);

    localparam int unsigned PROD_W = 2 * DATA_W;
    localparam int unsigned ACC_W  = acc_width(DATA_W, KERN_LEN);

    logic signed [PROD_W-1:0] prod_q [KERN_LEN];
    logic                     prod_valid_q;
    logic                     prod_last_q;
    logic signed [ACC_W-1:0]  acc_c;

    // Stage 1: one full-width product per tap.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < int'(KERN_LEN); k++) begin
                prod_q[k] <= '0;
            end
            prod_valid_q <= 1'b0;
            prod_last_q  <= 1'b0;
        end else if (en) begin
            for (int k = 0; k < int'(KERN_LEN); k++) begin
                prod_q[k] <= PROD_W'(signed'(win[k*DATA_W +: DATA_W]))
                           * PROD_W'(signed'(kern[k*DATA_W +: DATA_W]));
            end
            prod_valid_q <= in_valid;
            prod_last_q  <= in_last;
        end
    end

    // Adder tree over the registered products at accumulator width.
    always_comb begin
        acc_c = '0;
        for (int k = 0; k < int'(KERN_LEN); k++) begin
            acc_c = acc_c + ACC_W'(prod_q[k]);
        end
    end

    // Stage 2: saturate the sum into the output register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else if (en) begin
            out_valid <= prod_valid_q;
            out_last  <= prod_last_q;
            out_data  <= OUT_W'(sat_to(64'(acc_c), OUT_W));
        end
    end

endmodule

// File: rtl/conv1d_stream_engine.sv
// Row convolution engine: latches a pixel row, slides a runtime-loaded kernel
// across it and streams saturated results over valid/ready.
module conv1d_stream_engine
    import conv_pkg::*;
#(
    parameter int unsigned ROW_LEN  = 32,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned KERN_LEN = 3,
    parameter int unsigned OUT_W    = 18
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          same_mode,
    input  logic [ROW_LEN*DATA_W-1:0]     pixel_row_data,
    input  logic                          kern_wr_en,
    input  logic [$clog2(KERN_LEN)-1:0]   kern_wr_addr,
    input  logic [DATA_W-1:0]             kern_wr_data,
    output logic                          busy,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [OUT_W-1:0]              out_data,
    output logic                          out_last,
    output logic                          done_signal
);

    localparam int unsigned N_VALID = ROW_LEN - KERN_LEN + 1;
    localparam int unsigned IDX_W   = $clog2(ROW_LEN + 1);

    state_t                        state;
    logic [ROW_LEN*DATA_W-1:0]     row_q;
    logic                          same_q;
    logic [IDX_W-1:0]              idx_q;
    logic [DATA_W-1:0]             kern_q [KERN_LEN];
    logic [KERN_LEN*DATA_W-1:0]    kern_flat_c;
    logic [KERN_LEN*DATA_W-1:0]    win_c;
    logic [KERN_LEN*DATA_W-1:0]    win_q;
    logic                          win_valid_q;
    logic                          win_last_q;
    logic [IDX_W-1:0]              last_idx_c;
    logic                          en_c;

    // Pipeline advances unless a result is waiting on downstream.
    assign en_c       = !(out_valid && !out_ready);
    assign last_idx_c = same_q ? IDX_W'(ROW_LEN - 1) : IDX_W'(N_VALID - 1);

    // Flatten the weight registers for the MAC.
    always_comb begin
        kern_flat_c = '0;
        for (int k = 0; k < int'(KERN_LEN); k++) begin
            kern_flat_c[k*DATA_W +: DATA_W] = kern_q[k];
        end
    end

    // Gather the window for idx_q; positions off the row edge read as zero.
    always_comb begin
        int off;
        int pos;
        win_c = '0;
        off   = same_q ? (int'(KERN_LEN) - 1) / 2 : 0;
        pos   = 0;
        for (int k = 0; k < int'(KERN_LEN); k++) begin
            pos = int'(idx_q) + k - off;
            for (int n = 0; n < int'(ROW_LEN); n++) begin
                if (n == pos) begin
                    win_c[k*DATA_W +: DATA_W] = row_q[n*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Control FSM, row/kernel registers and window issue.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done_signal <= 1'b0;
            row_q       <= '0;
            same_q      <= 1'b0;
            idx_q       <= '0;
            win_q       <= '0;
            win_valid_q <= 1'b0;
            win_last_q  <= 1'b0;
            for (int k = 0; k < int'(KERN_LEN); k++) begin
                kern_q[k] <= '0;
            end
        end else begin
            done_signal <= 1'b0;
            case (state)
                IDLE: begin
                    // A weight write takes priority over start in the same cycle.
                    if (kern_wr_en) begin
                        if (32'(kern_wr_addr) < KERN_LEN) begin
                            kern_q[kern_wr_addr] <= kern_wr_data;
                        end
                    end else if (start) begin
                        row_q  <= pixel_row_data;
                        same_q <= same_mode;
                        idx_q  <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    if (en_c) begin
                        win_q       <= win_c;
                        win_valid_q <= 1'b1;
                        win_last_q  <= (idx_q == last_idx_c);
                        idx_q       <= idx_q + IDX_W'(1);
                        if (idx_q == last_idx_c) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (en_c) begin
                        win_valid_q <= 1'b0;
                        win_last_q  <= 1'b0;
                    end
                    if (out_valid && out_ready && out_last) begin
                        busy        <= 1'b0;
                        done_signal <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    conv_window_mac #(
        .DATA_W   (DATA_W),
        .KERN_LEN (KERN_LEN),
        .OUT_W    (OUT_W)
    ) u_mac (
        .clk       (clk),
        .rst       (rst),
        .en        (en_c),
        .in_valid  (win_valid_q),
        .in_last   (win_last_q),
        .win       (win_q),
        .kern      (kern_flat_c),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_data  (out_data)
    );

endmodule
